// File: rtl/cobs_frame_pkg.sv
// Shared types and sizing for the COBS frame controller.
package cobs_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_CHECK   = 3'd2,
      ST_READY   = 3'd3,
      ST_DROP    = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ERR_OVERRUN  = 2'd0,
      ERR_OVERFLOW = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_CHECKSUM = 2'd3
   } err_e;

   // Bits needed to hold a byte count in 0..max_len
   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int unsigned MAX_LEN_DFLT = 32;
   localparam int unsigned LEN_W        = $clog2(MAX_LEN_DFLT + 1);

endpackage

// File: rtl/cobs_frame_buf.sv
// Frame byte store: one write port, one registered read port.
module cobs_frame_buf
   import cobs_frame_pkg::*;
#(
   parameter int unsigned DEPTH = MAX_LEN_DFLT,
   parameter int unsigned AW    = LEN_W - 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] wa_i,
   input  logic [7:0]    wd_i,
   input  logic [AW-1:0] ra_i,
   output logic [7:0]    rd_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[wa_i] <= wd_i;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_o <= 8'h00;
      else     rd_o <= mem_q[ra_i];
   end

endmodule

// File: rtl/cobs_frame_ctrl.sv
// Collects decoded COBS bytes into a frame buffer and hands complete frames off.
// Optional trailing checksum byte when COBS_FRAME_CHECKSUM_EN is defined.
module cobs_frame_ctrl
   import cobs_frame_pkg::*;
#(
   parameter  int unsigned MAX_LEN     = 32,
   parameter  int unsigned TIMEOUT_CYC = 27000,
   localparam int unsigned LW          = len_w(MAX_LEN),
   localparam int unsigned AW          = LW - 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          raw_flag,
   input  logic [7:0]    raw_data,
   input  logic          dec_flag,
   input  logic [7:0]    dec_data,
   output logic          dec_busy,
   output logic          dec_clr,
   output logic          frm_valid,
   input  logic          frm_ready,
   output logic [LW-1:0] frm_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          err_flag,
   output logic [1:0]    err_code
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_e        state_q;
   logic [LW-1:0] cnt_q;
   logic [TW-1:0] idle_q;

   logic          any_flag_c;
   logic          delim_c;
   logic          full_c;
   logic          timing_st_c;
   logic          timeout_c;
   logic          wr_en_c;
   logic [AW-1:0] wr_addr_c;
   logic          frame_ok_c;
   logic [LW-1:0] len_c;

   always_comb begin
      any_flag_c  = raw_flag | dec_flag;
      delim_c     = raw_flag && (raw_data == 8'h00);
      full_c      = (cnt_q == LW'(MAX_LEN));
      timing_st_c = (state_q == ST_COLLECT) || (state_q == ST_DROP);
      timeout_c   = timing_st_c && !any_flag_c && (idle_q == TW'(TIMEOUT_CYC - 1));
      wr_en_c     = dec_flag && ((state_q == ST_IDLE) || ((state_q == ST_COLLECT) && !full_c));
      wr_addr_c   = (state_q == ST_IDLE) ? '0 : AW'(cnt_q);
   end

`ifdef COBS_FRAME_CHECKSUM_EN
   logic [7:0] sum_q;

   // Running sum restarts with the first byte of each frame
   always_ff @(posedge clk) begin
      if (rst)          sum_q <= 8'h00;
      else if (wr_en_c) sum_q <= (state_q == ST_IDLE) ? dec_data : sum_q + dec_data;
   end

   always_comb begin
      frame_ok_c = (cnt_q >= LW'(2)) && (sum_q == 8'h00);
      len_c      = cnt_q - LW'(1);
   end
`else
   always_comb begin
      frame_ok_c = 1'b1;
      len_c      = cnt_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idle_q    <= '0;
         frm_valid <= 1'b0;
         frm_len   <= '0;
         dec_busy  <= 1'b0;
         dec_clr   <= 1'b0;
         err_flag  <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         err_flag <= 1'b0;
         dec_clr  <= 1'b0;

         if (any_flag_c || !timing_st_c) idle_q <= '0;
         else                            idle_q <= idle_q + TW'(1);

         case (state_q)
            ST_IDLE: begin
               if (dec_flag) begin
                  cnt_q   <= LW'(1);
                  state_q <= ST_COLLECT;
               end
            end

            ST_COLLECT: begin
               if (timeout_c) begin
                  err_flag <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  dec_clr  <= 1'b1;
                  state_q  <= ST_IDLE;
               end else if (dec_flag && full_c) begin
                  // A delimiter in the same cycle already ends the dropped frame
                  err_flag <= 1'b1;
                  err_code <= ERR_OVERFLOW;
                  state_q  <= delim_c ? ST_IDLE : ST_DROP;
               end else begin
                  if (wr_en_c) cnt_q <= cnt_q + LW'(1);
                  if (delim_c) state_q <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (frame_ok_c) begin
                  frm_len   <= len_c;
                  frm_valid <= 1'b1;
                  dec_busy  <= 1'b1;
                  state_q   <= ST_READY;
               end else begin
                  err_flag <= 1'b1;
                  err_code <= ERR_CHECKSUM;
                  state_q  <= ST_IDLE;
               end
            end

            ST_READY: begin
               if (dec_flag) begin
                  err_flag <= 1'b1;
                  err_code <= ERR_OVERRUN;
               end
               if (frm_valid && frm_ready) begin
                  frm_valid <= 1'b0;
                  dec_busy  <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end

            ST_DROP: begin
               if (timeout_c) begin
                  err_flag <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  dec_clr  <= 1'b1;
                  state_q  <= ST_IDLE;
               end else if (delim_c) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   cobs_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .we_i (wr_en_c),
      .wa_i (wr_addr_c),
      .wd_i (dec_data),
      .ra_i (rd_addr),
      .rd_o (rd_data)
   );

endmodule

// File: tb/tb_cobs_frame_ctrl.sv
// Directed self-checking bench for cobs_frame_ctrl; expectations follow COBS_FRAME_CHECKSUM_EN.
module tb_cobs_frame_ctrl;
   import cobs_frame_pkg::*;

   localparam int unsigned MAXL = 32;
   localparam int unsigned TO   = 27000;
`ifdef COBS_FRAME_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam logic [1:0] C3 = CK ? 2'd3 : 2'd0;

   logic             clk;
   logic             rst;
   logic             raw_flag;
   logic [7:0]       raw_data;
   logic             dec_flag;
   logic [7:0]       dec_data;
   logic             dec_busy;
   logic             dec_clr;
   logic             frm_valid;
   logic             frm_ready;
   logic [LEN_W-1:0] frm_len;
   logic [LEN_W-2:0] rd_addr;
   logic [7:0]       rd_data;
   logic             err_flag;
   logic [1:0]       err_code;

   cobs_frame_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_flag  (raw_flag),
      .raw_data  (raw_data),
      .dec_flag  (dec_flag),
      .dec_data  (dec_data),
      .dec_busy  (dec_busy),
      .dec_clr   (dec_clr),
      .frm_valid (frm_valid),
      .frm_ready (frm_ready),
      .frm_len   (frm_len),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .err_flag  (err_flag),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rf;
      logic [7:0] rd;
      logic       df;
      logic [7:0] dd;
      logic       rdy;
      logic [4:0] ra;
      logic       xv;
      logic [5:0] xl;
      logic       xb;
      logic       xe;
      logic [1:0] xc;
      logic       cr;
      logic [7:0] xr;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic rf, input logic [7:0] rd, input logic df,
                               input logic [7:0] dd, input logic rdy, input logic [4:0] ra,
                               input logic xv, input logic [5:0] xl, input logic xb,
                               input logic xe, input logic [1:0] xc, input logic cr,
                               input logic [7:0] xr);
      vec_t v;
      v.rf = rf; v.rd = rd; v.df = df; v.dd = dd; v.rdy = rdy; v.ra = ra;
      v.xv = xv; v.xl = xl; v.xb = xb; v.xe = xe; v.xc = xc; v.cr = cr; v.xr = xr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rf, input logic [7:0] rd, input logic df,
                        input logic [7:0] dd, input logic rdy, input logic [4:0] ra);
      @(negedge clk);
      raw_flag  = rf;
      raw_data  = rd;
      dec_flag  = df;
      dec_data  = dd;
      frm_ready = rdy;
      rd_addr   = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [4:0] ra);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ra);
   endtask

   // Two-byte frame 0x42,0xBE (sums to zero), presented then taken
   task automatic send_ok(input string nm);
      drive(1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 5'd0);
      drive(1'b0, 8'h00, 1'b1, 8'hBE, 1'b0, 5'd0);
      drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0);
      idle(5'd0);
      chk({nm, " valid"}, frm_valid, 1'b1);
      chk({nm, " len"}, frm_len, CK ? 6'd1 : 6'd2);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0);
      chk({nm, " taken"}, frm_valid, 1'b0);
   endtask

   initial begin
      logic early;
      logic clr_early;
      logic busy_low;
      vec_t v;

      rst = 1'b1; raw_flag = 1'b0; raw_data = 8'h00; dec_flag = 1'b0;
      dec_data = 8'h00; frm_ready = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst frm_valid", frm_valid, 1'b0);
      chk("rst frm_len", frm_len, 6'd0);
      chk("rst dec_busy", dec_busy, 1'b0);
      chk("rst dec_clr", dec_clr, 1'b0);
      chk("rst err_flag", err_flag, 1'b0);
      chk("rst err_code", err_code, 2'd0);
      chk("rst rd_data", rd_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      //          rf  rd     df  dd     rdy ra     xv   xl             xb   xe  xc    cr  xr
      tbl.push_back(mk(0, 8'h00, 1, 8'h11, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h22, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h33, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h9A, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd0, 1, CK?6'd3:6'd4,  1,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd0, 1, CK?6'd3:6'd4,  1,  0, 2'd0, 1, 8'h11));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd1, 1, CK?6'd3:6'd4,  1,  0, 2'd0, 1, 8'h22));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd2, 1, CK?6'd3:6'd4,  1,  0, 2'd0, 1, 8'h33));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h11, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h22, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h33, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h9B, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 5'd0, 0, 6'd0,          0,  0, 2'd0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd0, !CK, 6'd4,        !CK, CK, C3,  0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd3, 0, 6'd0,          0,  0, C3,   1, 8'h9B));
      tbl.push_back(mk(0, 8'h00, 1, 8'h42, 0, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 1, 8'hBE, 0, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd0, 1, CK?6'd1:6'd2,  1,  0, C3,   0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 5'd1, 1, CK?6'd1:6'd2,  1,  0, C3,   1, 8'hBE));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));
      tbl.push_back(mk(1, 8'h37, 0, 8'h00, 0, 5'd0, 0, 6'd0,          0,  0, C3,   0, 8'h00));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.rf, v.rd, v.df, v.dd, v.rdy, v.ra);
         chk($sformatf("v%0d frm_valid", i), frm_valid, v.xv);
         if (v.xv) chk($sformatf("v%0d frm_len", i), frm_len, v.xl);
         chk($sformatf("v%0d dec_busy", i), dec_busy, v.xb);
         chk($sformatf("v%0d err_flag", i), err_flag, v.xe);
         chk($sformatf("v%0d err_code", i), err_code, v.xc);
         chk($sformatf("v%0d dec_clr", i), dec_clr, 1'b0);
         if (v.cr) chk($sformatf("v%0d rd_data", i), rd_data, v.xr);
      end

      // Overflow: 32 bytes fit, byte 33 errors, later bytes dropped until delimiter
      early = 1'b0;
      for (int i = 1; i <= 33; i++) begin
         drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 5'd0);
         if (i < 33 && err_flag) early = 1'b1;
      end
      chk("ovf early err", early, 1'b0);
      chk("ovf err_flag", err_flag, 1'b1);
      chk("ovf err_code", err_code, 2'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 5'd0);
         chk("ovf drop err_flag", err_flag, 1'b0);
      end
      idle(5'd31);
      chk("ovf last slot", rd_data, 8'h20);
      drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         idle(5'd0);
         chk("ovf no frame", frm_valid, 1'b0);
      end
      send_ok("ovf next");

      // Overrun: frame held 100 cycles with one stray decoded byte
      drive(1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 5'd0);
      drive(1'b0, 8'h00, 1'b1, 8'hB2, 1'b0, 5'd0);
      drive(1'b0, 8'h00, 1'b1, 8'hAD, 1'b0, 5'd0);
      drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0);
      idle(5'd0);
      chk("ovr valid", frm_valid, 1'b1);
      busy_low = 1'b0;
      for (int c = 0; c < 100; c++) begin
         drive(1'b0, 8'h00, c == 50, 8'h77, 1'b0, 5'd0);
         if (!dec_busy || !frm_valid) busy_low = 1'b1;
         if (c == 50) begin
            chk("ovr err_flag", err_flag, 1'b1);
            chk("ovr err_code", err_code, 2'd0);
         end
      end
      chk("ovr busy held", busy_low, 1'b0);
      chk("ovr len", frm_len, CK ? 6'd2 : 6'd3);
      idle(5'd0); chk("ovr rd0", rd_data, 8'hA1);
      idle(5'd1); chk("ovr rd1", rd_data, 8'hB2);
      idle(5'd2); chk("ovr rd2", rd_data, 8'hAD);
      idle(5'd3); chk("ovr rd3", rd_data, 8'h04);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0);
      chk("ovr taken", frm_valid, 1'b0);
      chk("ovr busy off", dec_busy, 1'b0);

      // Timeout: one byte then TO idle cycles
      drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 5'd0);
      early = 1'b0;
      clr_early = 1'b0;
      for (int c = 1; c <= int'(TO); c++) begin
         idle(5'd0);
         if (c < int'(TO)) begin
            if (err_flag) early = 1'b1;
            if (dec_clr) clr_early = 1'b1;
         end
      end
      chk("to early err", early, 1'b0);
      chk("to early clr", clr_early, 1'b0);
      chk("to err_flag", err_flag, 1'b1);
      chk("to err_code", err_code, 2'd2);
      chk("to dec_clr", dec_clr, 1'b1);
      idle(5'd0);
      chk("to clr pulse", dec_clr, 1'b0);
      chk("to err pulse", err_flag, 1'b0);
      chk("to code held", err_code, 2'd2);
      send_ok("to next");

      // Reset mid-frame
      drive(1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 5'd3);
      drive(1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 5'd3);
      @(negedge clk);
      dec_flag = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst frm_valid", frm_valid, 1'b0);
      chk("mrst frm_len", frm_len, 6'd0);
      chk("mrst dec_busy", dec_busy, 1'b0);
      chk("mrst dec_clr", dec_clr, 1'b0);
      chk("mrst err_flag", err_flag, 1'b0);
      chk("mrst err_code", err_code, 2'd0);
      chk("mrst rd_data", rd_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      idle(5'd0);
      chk("mrst no err", err_flag, 1'b0);
      send_ok("mrst next");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
